// File: rtl/agc_timer_pkg.sv
// Shared constants and types for the agc timer block.
// Selector codes, interrupt vector codes and the pending-flag bundle.
package agc_timer_pkg;

    localparam int CNT_W = 15;

    localparam logic [2:0] SEL_TIME1 = 3'd1;
    localparam logic [2:0] SEL_TIME2 = 3'd2;
    localparam logic [2:0] SEL_TIME3 = 3'd3;
    localparam logic [2:0] SEL_TIME4 = 3'd4;
    localparam logic [2:0] SEL_TIME5 = 3'd5;
    localparam logic [2:0] SEL_TIME6 = 3'd6;

    localparam logic [2:0] VEC_NONE = 3'd0;
    localparam logic [2:0] VEC_T6   = 3'd1;
    localparam logic [2:0] VEC_T5   = 3'd2;
    localparam logic [2:0] VEC_T3   = 3'd3;
    localparam logic [2:0] VEC_T4   = 3'd4;

    typedef struct packed {
        logic t6;
        logic t5;
        logic t3;
        logic t4;
    } pend_t;

endpackage

// File: rtl/agc_timers_if.sv
// Core-side bus of the timer block: counter read/write port
// plus the interrupt request/vector/acknowledge handshake.
interface agc_timers_if #(
    parameter int CNT_W = agc_timer_pkg::CNT_W
);
    logic             wr_en;
    logic [2:0]       wr_sel;
    logic [CNT_W-1:0] wr_data;
    logic [2:0]       rd_sel;
    logic [CNT_W-1:0] rd_data;
    logic             inhint;
    logic             rupt_req;
    logic [2:0]       rupt_vec;
    logic             rupt_ack;

    modport master (
        output wr_en, wr_sel, wr_data, rd_sel, inhint, rupt_ack,
        input  rd_data, rupt_req, rupt_vec
    );

    modport slave (
        input  wr_en, wr_sel, wr_data, rd_sel, inhint, rupt_ack,
        output rd_data, rupt_req, rupt_vec
    );
endinterface

// File: rtl/agc_prescaler.sv
// Centisecond prescaler: free-running 0..TICK_DIV-1 counter
// with a full tick at the top and a half tick at the midpoint.
module agc_prescaler #(
    parameter int TICK_DIV = 1024
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick_o,
    output logic half_tick_o
);
    localparam int PW = $clog2(TICK_DIV);

    logic [PW-1:0] pre_q;
    logic [PW-1:0] pre_d;

    assign tick_o      = (pre_q == PW'(TICK_DIV - 1));
    assign half_tick_o = (pre_q == PW'(TICK_DIV / 2 - 1));
    assign pre_d       = tick_o ? '0 : pre_q + 1'b1;

    // Advance the prescaler, wrapping after the tick cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pre_q <= '0;
        else        pre_q <= pre_d;
    end
endmodule

// File: rtl/agc_timers.sv
// agc TIME1..TIME6 counters and T3/T4/T5/T6 interrupt requests.
// Writes beat same-edge counter steps and never raise a request.
module agc_timers #(
    parameter int TICK_DIV = 1024,
    parameter int CNT_W    = agc_timer_pkg::CNT_W
) (
    input  logic        clk,
    input  logic        rst_n,
    agc_timers_if.slave bus
);
    import agc_timer_pkg::*;

    localparam logic [CNT_W-1:0] MAXV = '1;
    localparam logic [CNT_W-1:0] ONEV = CNT_W'(1);

    logic             tick;
    logic             half_tick;
    logic [CNT_W-1:0] cnt_q [1:6];
    logic [CNT_W-1:0] cnt_d [1:6];
    logic             arm_q;
    logic             arm_d;
    pend_t            pend_q;
    pend_t            pend_d;
    pend_t            set;
    pend_t            clr;
    logic [6:1]       wr_hit;
    logic             carry;
    logic [2:0]       vec;

    agc_prescaler #(.TICK_DIV(TICK_DIV)) u_pre (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick_o      (tick),
        .half_tick_o (half_tick)
    );

    // Decode which counter the write port targets this cycle.
    always_comb begin
        for (int i = 1; i <= 6; i++) begin
            wr_hit[i] = bus.wr_en && (bus.wr_sel == 3'(i));
        end
    end

    // Counter next state, TIME6 arm and wrap/expiry events.
    always_comb begin
        cnt_d = cnt_q;
        arm_d = arm_q;
        set   = '0;
        carry = tick && (cnt_q[1] == MAXV) && !wr_hit[1];
        if (tick)      cnt_d[1] = cnt_q[1] + 1'b1;
        if (carry)     cnt_d[2] = cnt_q[2] + 1'b1;
        if (tick)      cnt_d[3] = cnt_q[3] + 1'b1;
        if (half_tick) cnt_d[4] = cnt_q[4] + 1'b1;
        if (tick)      cnt_d[5] = cnt_q[5] + 1'b1;
        if (arm_q && tick) begin
            cnt_d[6] = cnt_q[6] - 1'b1;
            if (cnt_q[6] == ONEV) arm_d = 1'b0;
        end
        set.t3 = tick && (cnt_q[3] == MAXV) && !wr_hit[3];
        set.t4 = half_tick && (cnt_q[4] == MAXV) && !wr_hit[4];
        set.t5 = tick && (cnt_q[5] == MAXV) && !wr_hit[5];
        set.t6 = arm_q && tick && (cnt_q[6] == ONEV) && !wr_hit[6];
        for (int i = 1; i <= 6; i++) begin
            if (wr_hit[i]) cnt_d[i] = bus.wr_data;
        end
        if (wr_hit[6]) arm_d = |bus.wr_data;
    end

    // Fixed-priority vector: T6 > T5 > T3 > T4.
    always_comb begin
        if (pend_q.t6)      vec = VEC_T6;
        else if (pend_q.t5) vec = VEC_T5;
        else if (pend_q.t3) vec = VEC_T3;
        else if (pend_q.t4) vec = VEC_T4;
        else                vec = VEC_NONE;
    end

    // Ack clears only the source currently on the vector.
    always_comb begin
        clr = '0;
        if (bus.rupt_ack) begin
            case (vec)
                VEC_T6:  clr.t6 = 1'b1;
                VEC_T5:  clr.t5 = 1'b1;
                VEC_T3:  clr.t3 = 1'b1;
                VEC_T4:  clr.t4 = 1'b1;
                default: clr = '0;
            endcase
        end
        pend_d = (pend_q & ~clr) | set;
    end

    // Read mux; unused selects read as zero.
    always_comb begin
        case (bus.rd_sel)
            SEL_TIME1: bus.rd_data = cnt_q[1];
            SEL_TIME2: bus.rd_data = cnt_q[2];
            SEL_TIME3: bus.rd_data = cnt_q[3];
            SEL_TIME4: bus.rd_data = cnt_q[4];
            SEL_TIME5: bus.rd_data = cnt_q[5];
            SEL_TIME6: bus.rd_data = cnt_q[6];
            default:   bus.rd_data = '0;
        endcase
    end

    assign bus.rupt_vec = vec;
    assign bus.rupt_req = (|pend_q) && !bus.inhint;

    // Register counters, TIME6 arm and pending flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i <= 6; i++) cnt_q[i] <= '0;
            arm_q  <= 1'b0;
            pend_q <= '0;
        end else begin
            for (int i = 1; i <= 6; i++) cnt_q[i] <= cnt_d[i];
            arm_q  <= arm_d;
            pend_q <= pend_d;
        end
    end
endmodule

// File: tb/tb_agc_timers.sv
// Bench for agc_timers at TICK_DIV=4: directed scenarios then
// random traffic, both checked against a behavioural model.
module tb_agc_timers;
    import agc_timer_pkg::*;

    localparam int TD = 4;
    localparam int MOD = 32768;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    agc_timers_if #(.CNT_W(15)) bus ();

    agc_timers #(.TICK_DIV(TD), .CNT_W(15)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad = 0;

    int m_pre;
    int m_cnt [7];
    bit m_arm;
    bit p6, p5, p3, p4;

    function automatic int mvec();
        if (p6) return 1;
        if (p5) return 2;
        if (p3) return 3;
        if (p4) return 4;
        return 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pre = 0;
        for (int i = 0; i < 7; i++) m_cnt[i] = 0;
        m_arm = 0;
        p6 = 0; p5 = 0; p3 = 0; p4 = 0;
    endtask

    // Apply one clock edge to the model using the current inputs.
    task automatic model_edge();
        bit tk, hf, s3, s4, s5, s6, na;
        bit wr [7];
        int nc [7];
        tk = (m_pre == TD - 1);
        hf = (m_pre == TD / 2 - 1);
        for (int i = 0; i < 7; i++) begin
            wr[i] = bus.wr_en && (int'(bus.wr_sel) == i) && i >= 1 && i <= 6;
            nc[i] = m_cnt[i];
        end
        s3 = 0; s4 = 0; s5 = 0; s6 = 0;
        na = m_arm;
        if (tk) nc[1] = (m_cnt[1] + 1) % MOD;
        if (tk && m_cnt[1] == MOD - 1 && !wr[1]) nc[2] = (m_cnt[2] + 1) % MOD;
        if (tk) nc[3] = (m_cnt[3] + 1) % MOD;
        if (hf) nc[4] = (m_cnt[4] + 1) % MOD;
        if (tk) nc[5] = (m_cnt[5] + 1) % MOD;
        s3 = tk && m_cnt[3] == MOD - 1 && !wr[3];
        s4 = hf && m_cnt[4] == MOD - 1 && !wr[4];
        s5 = tk && m_cnt[5] == MOD - 1 && !wr[5];
        if (m_arm && tk) begin
            nc[6] = m_cnt[6] - 1;
            if (m_cnt[6] == 1) begin
                na = 0;
                s6 = !wr[6];
            end
        end
        for (int i = 1; i <= 6; i++) if (wr[i]) nc[i] = int'(bus.wr_data);
        if (wr[6]) na = (bus.wr_data != 0);
        if (bus.rupt_ack) begin
            case (mvec())
                1: p6 = 0;
                2: p5 = 0;
                3: p3 = 0;
                4: p4 = 0;
                default: ;
            endcase
        end
        p6 |= s6; p5 |= s5; p3 |= s3; p4 |= s4;
        for (int i = 0; i < 7; i++) m_cnt[i] = nc[i];
        m_arm = na;
        m_pre = (m_pre + 1) % TD;
    endtask

    task automatic step();
        int e;
        model_edge();
        @(posedge clk);
        #1;
        e = (bus.rd_sel >= 1 && bus.rd_sel <= 6) ? m_cnt[bus.rd_sel] : 0;
        chk("req", 32'(bus.rupt_req), 32'((p6 | p5 | p3 | p4) && !bus.inhint));
        chk("vec", 32'(bus.rupt_vec), 32'(mvec()));
        chk("rd", 32'(bus.rd_data), 32'(e));
        bus.wr_en = 1'b0;
        bus.rupt_ack = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic align(input int p);
        for (int i = 0; i < TD && m_pre != p; i++) step();
    endtask

    task automatic wr(input int sel, input int data);
        bus.wr_en = 1'b1;
        bus.wr_sel = 3'(sel);
        bus.wr_data = 15'(data);
        step();
    endtask

    task automatic ack();
        bus.rupt_ack = 1'b1;
        step();
    endtask

    task automatic rd(input int sel, input int exp, input string tag);
        bus.rd_sel = 3'(sel);
        #1;
        chk(tag, 32'(bus.rd_data), 32'(exp));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_req", 32'(bus.rupt_req), 32'd0);
        chk("rst_vec", 32'(bus.rupt_vec), 32'd0);
        for (int s = 1; s <= 6; s++) rd(s, 0, "rst_rd");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.wr_en = 1'b0;
        bus.wr_sel = '0;
        bus.wr_data = '0;
        bus.rd_sel = '0;
        bus.inhint = 1'b0;
        bus.rupt_ack = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        wr(3, 'h7FFF);
        idle(1);
        do_reset();
        idle(80);
        rd(3, 20, "idle_t3");
        chk("idle_vec", 32'(bus.rupt_vec), 32'd0);

        align(0);
        wr(1, 'h7FFF);
        idle(3);
        rd(1, 0, "wrap_t1");
        rd(2, 1, "carry_t2");
        chk("wrap_req", 32'(bus.rupt_req), 32'd0);

        align(0);
        wr(4, 'h7FFF);
        wr(3, 'h7FFF);
        chk("stag_t4", 32'(bus.rupt_vec), 32'd4);
        idle(2);
        chk("stag_t3", 32'(bus.rupt_vec), 32'd3);
        ack();
        chk("stag_ack1", 32'(bus.rupt_vec), 32'd4);
        ack();
        chk("stag_ack2", 32'(bus.rupt_vec), 32'd0);

        align(0);
        wr(6, 2);
        idle(3);
        rd(6, 1, "t6_one");
        idle(4);
        rd(6, 0, "t6_zero");
        chk("t6_vec", 32'(bus.rupt_vec), 32'd1);
        idle(8);
        rd(6, 0, "t6_hold");
        ack();
        chk("t6_ack", 32'(bus.rupt_vec), 32'd0);
        wr(6, 5);
        idle(4);
        wr(6, 0);
        idle(20);
        rd(6, 0, "t6_disarm");
        chk("t6_norupt", 32'(bus.rupt_vec), 32'd0);

        align(3);
        wr(5, 'h1234);
        rd(5, 'h1234, "wr_vs_tick");

        align(0);
        wr(5, 'h7FFF);
        idle(3);
        chk("t5_set", 32'(bus.rupt_vec), 32'd2);
        align(0);
        wr(5, 'h7FFF);
        idle(2);
        ack();
        chk("set_vs_ack", 32'(bus.rupt_vec), 32'd2);
        bus.inhint = 1'b1;
        #1;
        chk("inh_req", 32'(bus.rupt_req), 32'd0);
        chk("inh_vec", 32'(bus.rupt_vec), 32'd2);
        bus.inhint = 1'b0;
        #1;
        chk("uninh_req", 32'(bus.rupt_req), 32'd1);
        ack();
        chk("t5_clear", 32'(bus.rupt_vec), 32'd0);

        align(0);
        wr(4, 'h7FFF);
        wr(3, 'h7FFF);
        wr(5, 'h7FFF);
        idle(1);
        chk("pri_0", 32'(bus.rupt_vec), 32'd2);
        ack();
        chk("pri_1", 32'(bus.rupt_vec), 32'd3);
        ack();
        chk("pri_2", 32'(bus.rupt_vec), 32'd4);
        chk("pri_2req", 32'(bus.rupt_req), 32'd1);
        ack();
        chk("pri_3", 32'(bus.rupt_vec), 32'd0);
        chk("pri_3req", 32'(bus.rupt_req), 32'd0);

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 499) == 0) do_reset();
            bus.wr_en = ($urandom_range(0, 5) == 0);
            bus.wr_sel = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 5))
                0: bus.wr_data = 15'h7FFF;
                1: bus.wr_data = 15'h7FFE;
                2: bus.wr_data = 15'($urandom_range(0, 3));
                default: bus.wr_data = 15'($urandom);
            endcase
            bus.rupt_ack = ($urandom_range(0, 3) == 0);
            bus.inhint = ($urandom_range(0, 3) == 0);
            bus.rd_sel = 3'($urandom_range(0, 7));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
